// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling pipe obstacle for the Flappy Bird VGA path.
// Owns pipe position, pseudo-random gap height and score pulse, converts
// (px,py) into tile-local coordinates for the 16x16 sprite ROM and
// composites the returned tile colour over the background.
// Optional build macro: SPEEDUP_EN (scroll step grows by one every 8 wraps,
// saturating at 2*SCROLL_STEP).
// Interface note: the pixel stream has no valid/ready handshake; px/py are
// taken as valid on every clock, and oR/oG/oB are valid two edges later.
module pipe_scroller #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PIPE_W      = 64,
    parameter int GAP_H       = 128,
    parameter int GAP_MIN     = 32,
    parameter int SCROLL_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        vsync_tick,
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic [7:0]  blk_r,
    input  logic [7:0]  blk_g,
    input  logic [7:0]  blk_b,
    input  logic        blk_mask,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    output logic [10:0] tile_ix,
    output logic [10:0] tile_iy,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic [10:0] pipe_pos,
    output logic [10:0] gap_y,
    output logic        score_pulse,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        WRAP   = 2'd2
    } state_t;

    localparam logic [10:0] POS_RESET  = 11'(H_ACTIVE + PIPE_W);
    localparam logic [10:0] GAP_RESET  = 11'(GAP_MIN + 96);
    localparam logic [10:0] GAP_MIN11  = 11'(GAP_MIN);
    localparam logic [11:0] PIPE_W12   = 12'(PIPE_W);
    localparam logic [11:0] GAP_H12    = 12'(GAP_H);
    localparam logic [11:0] H_ACT12    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT12    = 12'(V_ACTIVE);
    localparam logic [11:0] STEP12     = 12'(SCROLL_STEP);

    state_t      state_q, state_d;
    logic [10:0] pipe_pos_q, pipe_pos_d;
    logic [10:0] gap_y_q, gap_y_d;
    logic        score_q, score_d;
    logic [7:0]  lfsr_q;
    logic [11:0] step;

`ifdef SPEEDUP_EN
    localparam logic [11:0] STEP_MAX12 = 12'(2 * SCROLL_STEP);
    logic [2:0]  wrap_cnt_q, wrap_cnt_d;
    logic [11:0] step_q, step_d;

    assign step = step_q;

    // Wrap counter and effective step register for the speed-up mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt_q <= 3'd0;
            step_q     <= STEP12;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
            step_q     <= step_d;
        end
    end
`else
    assign step = STEP12;
`endif

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); nonzero seed keeps it alive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Game-state registers: FSM state, pipe position, gap row, score pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pipe_pos_q <= POS_RESET;
            gap_y_q    <= GAP_RESET;
            score_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_pos_q <= pipe_pos_d;
            gap_y_q    <= gap_y_d;
            score_q    <= score_d;
        end
    end

    // Next-state logic: position only moves on a frame tick or on wrap.
    always_comb begin
        state_d    = state_q;
        pipe_pos_d = pipe_pos_q;
        gap_y_d    = gap_y_q;
        score_d    = 1'b0;
`ifdef SPEEDUP_EN
        wrap_cnt_d = wrap_cnt_q;
        step_d     = step_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) state_d = SCROLL;
            end
            SCROLL: begin
                if (vsync_tick) begin
                    if (!run)                           state_d = IDLE;
                    else if ({1'b0, pipe_pos_q} <= step) state_d = WRAP;
                    else                                pipe_pos_d = pipe_pos_q - step[10:0];
                end
            end
            WRAP: begin
                // Single cycle; a frame tick seen here is deliberately dropped.
                pipe_pos_d = POS_RESET;
                gap_y_d    = GAP_MIN11 + {4'b0, lfsr_q[6:0]};
                score_d    = 1'b1;
                state_d    = SCROLL;
`ifdef SPEEDUP_EN
                wrap_cnt_d = wrap_cnt_q + 3'd1;
                if (wrap_cnt_q == 3'd7 && step_q < STEP_MAX12) step_d = step_q + 12'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1 combinational: pipe hit test, tile coordinates, active window.
    logic [11:0] px12, py12, pos12, gap12, right12;
    logic        in_pipe_d, active_d;
    logic [3:0]  tile_nib;

    always_comb begin
        px12      = {1'b0, px};
        py12      = {1'b0, py};
        pos12     = {1'b0, pipe_pos_q};
        gap12     = {1'b0, gap_y_q};
        right12   = px12 + PIPE_W12;
        in_pipe_d = (right12 >= pos12) && (px12 < pos12) &&
                    ((py12 < gap12) || (py12 >= gap12 + GAP_H12));
        active_d  = (px12 < H_ACT12) && (py12 < V_ACT12);
        // Low nibble of (px + PIPE_W - pipe_pos); only 4 bits reach the ROM.
        tile_nib  = px[3:0] + PIPE_W12[3:0] - pipe_pos_q[3:0];
    end

    logic        in_pipe_q, active_q;
    logic [10:0] tile_ix_q, tile_iy_q;
    logic [7:0]  bg_r_q, bg_g_q, bg_b_q;

    // Stage 1 registers: tile address to the ROM plus delayed background.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pipe_q <= 1'b0;
            active_q  <= 1'b0;
            tile_ix_q <= 11'd0;
            tile_iy_q <= 11'd0;
            bg_r_q    <= 8'd0;
            bg_g_q    <= 8'd0;
            bg_b_q    <= 8'd0;
        end else begin
            in_pipe_q <= in_pipe_d;
            active_q  <= active_d;
            tile_ix_q <= {7'b0, tile_nib};
            tile_iy_q <= {7'b0, py[3:0]};
            bg_r_q    <= bg_r;
            bg_g_q    <= bg_g;
            bg_b_q    <= bg_b;
        end
    end

    logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;

    // Stage 2 select: blank outside active video, opaque tile pixels win.
    always_comb begin
        r_d = 8'd0;
        g_d = 8'd0;
        b_d = 8'd0;
        if (active_q) begin
            if (in_pipe_q && blk_mask) begin
                r_d = blk_r;
                g_d = blk_g;
                b_d = blk_b;
            end else begin
                r_d = bg_r_q;
                g_d = bg_g_q;
                b_d = bg_b_q;
            end
        end
    end

    // Stage 2 registers: composited output pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 8'd0;
            g_q <= 8'd0;
            b_q <= 8'd0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign tile_ix     = tile_ix_q;
    assign tile_iy     = tile_iy_q;
    assign oR          = r_q;
    assign oG          = g_q;
    assign oB          = b_q;
    assign pipe_pos    = pipe_pos_q;
    assign gap_y       = gap_y_q;
    assign score_pulse = score_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Testbench for pipe_scroller: directed scrolling/wrap/reset checks plus a
// queue-based scoreboard for the two-stage pixel compositing path.
module tb_pipe_scroller;

  logic        clk = 1'b0;
  logic        rst, run, vsync_tick;
  logic [10:0] px, py;
  logic [7:0]  blk_r, blk_g, blk_b, bg_r, bg_g, bg_b;
  logic        blk_mask;
  logic [10:0] tile_ix, tile_iy, pipe_pos, gap_y;
  logic [7:0]  oR, oG, oB;
  logic        score_pulse;
  logic [1:0]  dbg_state;

  pipe_scroller dut (
    .clk(clk), .rst(rst), .run(run), .vsync_tick(vsync_tick),
    .px(px), .py(py),
    .blk_r(blk_r), .blk_g(blk_g), .blk_b(blk_b), .blk_mask(blk_mask),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .tile_ix(tile_ix), .tile_iy(tile_iy),
    .oR(oR), .oG(oG), .oB(oB),
    .pipe_pos(pipe_pos), .gap_y(gap_y), .score_pulse(score_pulse),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [45:0] exp_q[$];
  logic [45:0] exp_e;
  logic        tb_vld = 1'b0;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // marks when a pushed pixel vector reaches the registered output
  always @(posedge clk) begin
    v1 <= tb_vld;
    v2 <= v1;
  end

  // monitor: score pulses and scoreboard pops
  always @(negedge clk) begin
    if (score_pulse && !rst) pulse_cnt++;
    if (v2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_underflow actual=output required=queued_expectation");
      end else begin
        exp_e = exp_q.pop_front();
        check("pix_ix_iy_rgb", {18'd0, tile_ix, tile_iy, oR, oG, oB}, {18'd0, exp_e});
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1 vsync_tick = 1'b1;
    @(posedge clk); #1 vsync_tick = 1'b0;
  endtask

  // sel: 0 = blank, 1 = tile colour, 2 = background
  task automatic send_pix(input logic [10:0] x, input logic [10:0] y, input logic m,
                          input logic [10:0] eix, input logic [10:0] eiy, input int sel,
                          input int k);
    logic [7:0] er, eg, eb;
    px = x; py = y; blk_mask = m;
    blk_r = 8'hE0; blk_g = 8'h1A; blk_b = 8'h3C;
    bg_r = 8'h40 + 8'(k); bg_g = 8'h50 + 8'(k); bg_b = 8'h60 + 8'(k);
    case (sel)
      1:       begin er = 8'hE0;         eg = 8'h1A;         eb = 8'h3C;         end
      2:       begin er = 8'h40 + 8'(k); eg = 8'h50 + 8'(k); eb = 8'h60 + 8'(k); end
      default: begin er = 8'h00;         eg = 8'h00;         eb = 8'h00;         end
    endcase
    exp_q.push_back({eix, eiy, er, eg, eb});
    tb_vld = 1'b1;
    @(posedge clk); #1 tb_vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; vsync_tick = 1'b0;
    px = 11'd0; py = 11'd0; blk_mask = 1'b0;
    blk_r = 8'd0; blk_g = 8'd0; blk_b = 8'd0;
    bg_r = 8'd0; bg_g = 8'd0; bg_b = 8'd0;
    cyc(2);

    // reset state
    check("rst_pipe_pos", pipe_pos, 704);
    check("rst_gap_y", gap_y, 128);
    check("rst_rgb", {oR, oG, oB}, 0);
    check("rst_tile", {tile_ix, tile_iy}, 0);
    check("rst_score", score_pulse, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // scroll 10 frames, then stop
    run = 1'b1;
    cyc(1);
    check("idle_to_scroll", dbg_state, 1);
    repeat (10) tick();
    cyc(1);
    check("scroll10_pos", pipe_pos, 684);
    run = 1'b0;
    repeat (5) tick();
    cyc(1);
    check("frozen_pos", pipe_pos, 684);
    check("frozen_state", dbg_state, 0);

    // asynchronous reset mid-frame with a pipe pixel in the output
    px = 11'd630; py = 11'd0; blk_mask = 1'b1;
    blk_r = 8'hE0; blk_g = 8'h1A; blk_b = 8'h3C;
    bg_r = 8'h55; bg_g = 8'h66; bg_b = 8'h77;
    cyc(3);
    check("pre_rst_oR", oR, 8'hE0);
    check("pre_rst_ix", tile_ix, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_pos", pipe_pos, 704);
    check("mid_rst_gap", gap_y, 128);
    check("mid_rst_rgb", {oR, oG, oB}, 0);
    check("mid_rst_tile", {tile_ix, tile_iy}, 0);
    check("mid_rst_score", score_pulse, 0);
    @(negedge clk);
    rst = 1'b0;

    // wrap, with a frame tick held into the WRAP cycle
    run = 1'b1;
    cyc(1);
    repeat (351) tick();
    cyc(1);
    check("pre_wrap_pos", pipe_pos, 2);
    check("pre_wrap_pulses", pulse_cnt, 0);
    @(posedge clk); #1 vsync_tick = 1'b1;
    @(posedge clk); #1;
    check("wrap_state", dbg_state, 2);
    check("wrap_pos_hold", pipe_pos, 2);
    @(posedge clk); #1 vsync_tick = 1'b0;
    check("post_wrap_pos", pipe_pos, 704);
    check("post_wrap_score", score_pulse, 1);
    check("post_wrap_state", dbg_state, 1);
    cyc(3);
    check("wrap_pulse_count", pulse_cnt, 1);
    check("wrap_tick_ignored", pipe_pos, 704);
    check("gap_in_range", (gap_y >= 11'd32) && (gap_y <= 11'd159), 1);

    // reset landing inside WRAP cancels the score pulse
    repeat (351) tick();
    cyc(1);
    check("pre_wrap2_pos", pipe_pos, 2);
    @(posedge clk); #1 vsync_tick = 1'b1;
    @(posedge clk); #1 vsync_tick = 1'b0;
    check("wrap2_state", dbg_state, 2);
    #2 rst = 1'b1;
    #1;
    check("wrap_rst_state", dbg_state, 0);
    check("wrap_rst_pos", pipe_pos, 704);
    check("wrap_rst_gap", gap_y, 128);
    check("wrap_rst_score", score_pulse, 0);
    cyc(4);
    rst = 1'b0;
    cyc(2);
    check("wrap_rst_pulses", pulse_cnt, 1);

    // bring pipe to 320 (gap rows 128..255) for compositing
    run = 1'b1;
    cyc(1);
    repeat (192) tick();
    cyc(1);
    check("pix_setup_pos", pipe_pos, 320);
    check("pix_setup_gap", gap_y, 128);

    send_pix(11'd260, 11'd0,   1'b1, 11'd4,  11'd0,  1, 0);
    send_pix(11'd260, 11'd200, 1'b1, 11'd4,  11'd8,  2, 1);
    send_pix(11'd260, 11'd0,   1'b0, 11'd4,  11'd0,  2, 2);
    send_pix(11'd700, 11'd0,   1'b1, 11'd12, 11'd0,  0, 3);
    send_pix(11'd100, 11'd10,  1'b1, 11'd4,  11'd10, 2, 4);
    send_pix(11'd319, 11'd300, 1'b1, 11'd15, 11'd12, 1, 5);
    send_pix(11'd256, 11'd255, 1'b1, 11'd0,  11'd15, 2, 6);
    send_pix(11'd300, 11'd479, 1'b1, 11'd12, 11'd15, 1, 7);
    send_pix(11'd300, 11'd480, 1'b1, 11'd12, 11'd0,  0, 8);
    send_pix(11'd639, 11'd0,   1'b1, 11'd15, 11'd0,  2, 9);
    send_pix(11'd256, 11'd127, 1'b1, 11'd0,  11'd15, 1, 10);
    send_pix(11'd255, 11'd127, 1'b1, 11'd15, 11'd15, 2, 11);

    cyc(4);
    check("scoreboard_drained", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
